// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller FSM states, frame width and the
// register map decoded by spi_peripheral.
package spi_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

    localparam logic [6:0] ADDR_OUT_7_0    = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8   = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0    = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8   = 7'h03;
    localparam logic [6:0] ADDR_DUTY_CYCLE = 7'h04;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: serialises one {rw, addr[6:0], data[7:0]}
// frame per accepted request, MSB first, on nCS/SCLK/COPI.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    localparam int unsigned CNT_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    spi_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [FRAME_W-1:0] shift_r;
    logic               req_ready_r;
    logic               done_r;
    logic               ncs_r;
    logic               sclk_r;
    logic               copi_r;
    logic               hp_end_s;
    logic               gap_end_s;

    assign hp_end_s  = (cnt_r == HP_LAST);
    assign gap_end_s = (cnt_r == GAP_LAST);

    // Frame sequencer; every bus output is a register so nCS/SCLK/COPI never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            bit_cnt_r   <= BIT_ZERO;
            shift_r     <= {FRAME_W{1'b0}};
            req_ready_r <= 1'b1;
            done_r      <= 1'b0;
            ncs_r       <= 1'b1;
            sclk_r      <= 1'b0;
            copi_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        shift_r     <= build_frame(req_rw, req_addr, req_data);
                        copi_r      <= req_rw;
                        ncs_r       <= 1'b0;
                        bit_cnt_r   <= BIT_ZERO;
                        cnt_r       <= CNT_ZERO;
                        req_ready_r <= 1'b0;
                        state_r     <= SETUP;
                    end
                end
                SETUP: begin
                    if (hp_end_s) begin
                        cnt_r   <= CNT_ZERO;
                        sclk_r  <= 1'b1;
                        state_r <= HIGH;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (hp_end_s) begin
                        cnt_r  <= CNT_ZERO;
                        sclk_r <= 1'b0;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= HOLD;
                        end else begin
                            // COPI only moves on the falling edge, keeping it stable across rises.
                            shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
                            copi_r    <= shift_r[FRAME_W-2];
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            state_r   <= LOW;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                LOW: begin
                    if (hp_end_s) begin
                        cnt_r   <= CNT_ZERO;
                        sclk_r  <= 1'b1;
                        state_r <= HIGH;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (hp_end_s) begin
                        cnt_r   <= CNT_ZERO;
                        ncs_r   <= 1'b1;
                        copi_r  <= 1'b0;
                        state_r <= GAP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                GAP: begin
                    if (gap_end_s) begin
                        cnt_r       <= CNT_ZERO;
                        done_r      <= 1'b1;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= CNT_ZERO;
                    bit_cnt_r   <= BIT_ZERO;
                    req_ready_r <= 1'b1;
                    ncs_r       <= 1'b1;
                    sclk_r      <= 1'b0;
                    copi_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign done      = done_r;
    assign nCS       = ncs_r;
    assign SCLK      = sclk_r;
    assign COPI      = copi_r;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a behavioural peripheral samples COPI on
// every SCLK rise and commits complete write frames to a register array.
module tb_spi_controller;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       done, ncs, sclk, copi;

    logic       req_valid2, req_ready2, req_rw2;
    logic [6:0] req_addr2;
    logic [7:0] req_data2;
    logic       done2, ncs2, sclk2, copi2;

    always #5 clk = ~clk;

    spi_controller #(.HALF_PERIOD(4), .CS_GAP(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .done(done),
        .nCS(ncs), .SCLK(sclk), .COPI(copi)
    );

    spi_controller #(.HALF_PERIOD(2), .CS_GAP(4)) dut_min (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_rw(req_rw2), .req_addr(req_addr2), .req_data(req_data2), .done(done2),
        .nCS(ncs2), .SCLK(sclk2), .COPI(copi2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model for the default-divider instance
    logic [15:0] sh = 16'h0000, last_frame = 16'h0000;
    int          rises = 0, last_rises = 0;
    logic [7:0]  regs [0:127] = '{default: 8'h00};

    always @(negedge ncs) begin
        sh    = 16'h0000;
        rises = 0;
    end
    always @(posedge sclk) if (ncs === 1'b0) begin
        sh    = {sh[14:0], copi};
        rises = rises + 1;
    end
    always @(posedge ncs) begin
        last_frame = sh;
        last_rises = rises;
        if (rises == 16 && sh[15] == 1'b1) regs[sh[14:8]] = sh[7:0];
    end

    // Peripheral model for the minimum-divider instance
    logic [15:0] sh2 = 16'h0000, last_frame2 = 16'h0000;
    int          rises2 = 0, last_rises2 = 0;
    logic [7:0]  regs2 [0:127] = '{default: 8'h00};

    always @(negedge ncs2) begin
        sh2    = 16'h0000;
        rises2 = 0;
    end
    always @(posedge sclk2) if (ncs2 === 1'b0) begin
        sh2    = {sh2[14:0], copi2};
        rises2 = rises2 + 1;
    end
    always @(posedge ncs2) begin
        last_frame2 = sh2;
        last_rises2 = rises2;
        if (rises2 == 16 && sh2[15] == 1'b1) regs2[sh2[14:8]] = sh2[7:0];
    end

    // done pulse counter and shortest nCS-high stretch between frames
    int done_cnt = 0;
    int hi_run   = 0;
    int min_gap  = 100000;
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (ncs === 1'b1) begin
            hi_run = hi_run + 1;
        end else begin
            if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request on the default instance, measure done latency and nCS-low cycles.
    task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                        output int lat, output int lows);
        int  t;
        int  acc;
        bit  got;
        lat  = -1;
        lows = 0;
        t    = 0;
        got  = 1'b0;
        @(negedge clk);
        req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_rw = ~rw; req_addr = ~a; req_data = ~d;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (ncs == 1'b0) lows++;
            if (done == 1'b1) begin
                got = 1'b1;
                lat = cyc - acc;
            end
        end
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_frame;
        logic [7:0]  exp_reg;
    } vec_t;

    vec_t vecs [4];
    logic [6:0] bb_addr [3];
    logic [7:0] bb_data [3];
    int         acc_t [3];

    initial begin
        int lat, lows, t, done_before;
        vecs[0] = '{1'b1, ADDR_OUT_7_0,    8'hFF, 16'h80FF, 8'hFF};
        vecs[1] = '{1'b1, ADDR_DUTY_CYCLE, 8'h80, 16'h8480, 8'h80};
        vecs[2] = '{1'b0, ADDR_PWM_7_0,    8'h55, 16'h0255, 8'h00};
        vecs[3] = '{1'b1, ADDR_PWM_15_8,   8'h3C, 16'h833C, 8'h3C};
        bb_addr[0] = ADDR_OUT_7_0;  bb_data[0] = 8'h01;
        bb_addr[1] = ADDR_OUT_15_8; bb_data[1] = 8'h02;
        bb_addr[2] = ADDR_PWM_15_8; bb_data[2] = 8'hF0;

        rst = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 7'h00; req_data = 8'h00;
        req_valid2 = 1'b0; req_rw2 = 1'b0; req_addr2 = 7'h00; req_data2 = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ncs",   int'(ncs),       1);
        check("reset_sclk",  int'(sclk),      0);
        check("reset_copi",  int'(copi),      0);
        check("reset_ready", int'(req_ready), 1);
        check("reset_done",  int'(done),      0);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].rw, vecs[i].addr, vecs[i].data, lat, lows);
            check("vec_done_latency", lat, 136);
            check("vec_ncs_low",      lows, 132);
            check("vec_rises",        last_rises, 16);
            check("vec_frame",        int'(last_frame), int'(vecs[i].exp_frame));
            check("vec_reg",          int'(regs[vecs[i].addr]), int'(vecs[i].exp_reg));
        end

        // Back-to-back: valid held high, fields replaced right after each accept
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = bb_addr[0]; req_data = bb_data[0];
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (!req_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            acc_t[i] = cyc + 1;
            @(posedge clk);
            #1;
            if (i < 2) begin
                req_addr = bb_addr[i+1]; req_data = bb_data[i+1];
            end else begin
                req_valid = 1'b0;
            end
        end
        t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("b2b_period_1", acc_t[1] - acc_t[0], 137);
        check("b2b_period_2", acc_t[2] - acc_t[1], 137);
        check("b2b_min_gap_ge4", int'(min_gap >= 4), 1);
        check("b2b_reg_out_7_0",  int'(regs[ADDR_OUT_7_0]),  8'h01);
        check("b2b_reg_out_15_8", int'(regs[ADDR_OUT_15_8]), 8'h02);
        check("b2b_reg_pwm_15_8", int'(regs[ADDR_PWM_15_8]), 8'hF0);

        // Reset after the 8th rise of a write to out_7_0
        @(negedge clk);
        req_rw = 1'b1; req_addr = ADDR_OUT_7_0; req_data = 8'h77; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        t = 0;
        while (rises < 8 && t < 200) begin
            @(negedge clk);
            t++;
        end
        done_before = done_cnt;
        rst = 1'b1;
        #1;
        check("midrst_ncs",  int'(ncs),  1);
        check("midrst_sclk", int'(sclk), 0);
        check("midrst_rises_seen", last_rises, 8);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst_no_done", done_cnt - done_before, 0);
        check("midrst_reg_kept", int'(regs[ADDR_OUT_7_0]), 8'h01);
        check("midrst_ready", int'(req_ready), 1);
        send(1'b1, ADDR_OUT_7_0, 8'h5A, lat, lows);
        check("post_rst_latency", lat, 136);
        check("post_rst_reg", int'(regs[ADDR_OUT_7_0]), 8'h5A);

        // Minimum divider instance
        @(negedge clk);
        req_rw2 = 1'b1; req_addr2 = ADDR_OUT_15_8; req_data2 = 8'hA5; req_valid2 = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        req_valid2 = 1'b0; req_addr2 = 7'h7F; req_data2 = 8'h00;
        lows = 0;
        lat  = -1;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(negedge clk);
            if (ncs2 == 1'b0) lows++;
            if (done2 == 1'b1) lat = cyc - t;
        end
        check("min_ncs_low",  lows, 66);
        check("min_latency",  lat, 70);
        check("min_rises",    last_rises2, 16);
        check("min_frame",    int'(last_frame2), 16'h81A5);
        check("min_reg",      int'(regs2[ADDR_OUT_15_8]), 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI write-initiator that drives the 3-wire bus (nCS, SCLK, COPI) consumed by the on-chip `spi_peripheral` register block. It serialises one 16-bit frame per request: R/W bit, 7-bit address, 8-bit data, MSB first, SPI mode 0. The block serves as the bench/loopback driver and as the master used when one chip configures another's PWM/output-enable registers.

## Interface
Parameters:
- `HALF_PERIOD`, 4: clk cycles per SCLK half-period. Legal minimum is 2, so the peripheral's synchroniser sees each level.
- `CS_GAP`, 4: clk cycles nCS is held high after a frame before `req_ready` returns.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  controller can accept a request.
- `req_rw`  in  1  frame bit 15 (1 = write, 0 = read/ignored by peripheral).
- `req_addr`  in  7  register address, frame bits 14:8.
- `req_data`  in  8  write data, frame bits 7:0.
- `done`  out  1  one-cycle pulse when a frame and its gap complete.
- `nCS`  out  1  chip select, active low.
- `SCLK`  out  1  serial clock, idle low.
- `COPI`  out  1  serial data out.

## Operation
- All outputs are registered. Reset values: `nCS`=1, `SCLK`=0, `COPI`=0, `req_ready`=1, `done`=0, state IDLE, counters 0.
- Frame: {`req_rw`, `req_addr`, `req_data`}. It is latched into a 16-bit shift register on accept (`req_valid` && `req_ready`).
- The controller works through the following states in order:
  - **IDLE**: `req_ready`=1. On accept, go to SETUP. `nCS`=0, `COPI`=frame[15], bit count=0.
  - **SETUP**: hold for HALF_PERIOD cycles, then go to HIGH with `SCLK`=1.
  - **HIGH**: hold for HALF_PERIOD cycles.
    - If the bit count is 15, go to HOLD with `SCLK`=0.
    - Otherwise go to LOW with `SCLK`=0, shift the frame left, drive `COPI` with the next bit, and increment the bit count.
  - **LOW**: hold for HALF_PERIOD cycles, then go to HIGH with `SCLK`=1.
  - **HOLD**: hold for HALF_PERIOD cycles, then go to GAP with `nCS`=1 and `COPI`=0.
  - **GAP**: hold for CS_GAP cycles, then go to IDLE and assert `done` for 1 cycle.
- `COPI` changes only on SCLK falling edges, or at nCS assertion for bit 15. It is stable across every rising edge.
- Exactly 16 SCLK rising edges occur per frame.
- `req_valid` is ignored outside IDLE. The request fields are not sampled after accept and may change freely.
- Reset asserted mid-frame immediately forces the idle levels (`nCS`=1, `SCLK`=0). The peripheral discards the partial frame. No `done` pulse is issued.
- `req_rw`=0 frames are transmitted identically. Ignoring them is the peripheral's job.

## Timing
- Accept occurs at clk edge k. Then:
  - `nCS` falls after edge k.
  - The first SCLK rise is after edge k+HALF_PERIOD.
  - The n-th rise (n=1..16) is after edge k+(2n−1)·HALF_PERIOD.
  - The last SCLK fall is after k+32·HALF_PERIOD.
  - `nCS` rises after k+33·HALF_PERIOD, which is 132 cycles at the defaults.
- `done` and `req_ready` go high together after edge k+33·HALF_PERIOD+CS_GAP, which is 136 cycles at the defaults.
- A new request may be accepted in the cycle `done` is high. The back-to-back frame period is 33·HALF_PERIOD+CS_GAP+1 cycles.
- Setup and hold of `COPI` around each rising edge are both HALF_PERIOD clk cycles.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, HOLD, GAP);
  - `FRAME_W`=16;
  - the register address constants: 0x00 out_7_0, 0x01 out_15_8, 0x02 pwm_7_0, 0x03 pwm_15_8, 0x04 duty_cycle.
- `spi_peripheral` must import the same constants.
- Single module, no sub-module. The half-period counter is inline and shared by SETUP/HIGH/LOW/HOLD/GAP; it is wide enough for max(HALF_PERIOD, CS_GAP).

## Test plan
All scenarios loop the controller back into `spi_peripheral`.
- **Write out_7_0**: write addr 0x00 data 0xFF → COPI on rises = 1,0000000,11111111. Exactly 16 rises. `en_reg_out_7_0`=0xFF. `done` arrives 136 cycles after accept.
- **Duty-cycle write**: write addr 0x04 data 0x80 → `pwm_duty_cycle`=0x80. nCS is low for exactly 132 cycles.
- **Read frame ignored**: read (rw=0) addr 0x02 data 0x55 → identical waveform shape. `en_reg_pwm_7_0` is unchanged from 0x00.
- **Back-to-back**: valid held high with three requests (0x00/0x01, 0x01/0x02, 0x03/0xF0) → frames start 137 cycles apart. nCS is high ≥4 cycles between frames. All three registers are updated.
- **Reset mid-frame**: pulse `rst` after the 8th rise → nCS=1 and SCLK=0 immediately. Peripheral registers are unchanged. No `done`. The next request completes normally.
- **Minimum divider**: `HALF_PERIOD`=2 with write 0x01/0xA5 → `en_reg_out_15_8`=0xA5. nCS is low for 66 cycles.
